kfmmc_card_command_io: RTL and testbench
========================================

# kfmmc_card_command_io

Card-side counterpart of the KFMMC host command channel. It deserialises 48-bit host command frames from the MMC CMD line, checks CRC7 and framing, and presents index and argument to the card model. It then serialises a 48-bit or 136-bit response frame back onto CMD after the Ncr gap. It sits between the bit-level CMD pin logic and the card state machine of the KFMMC card emulator and test bench.

## Interface
Parameters:
- NCR_CYCLES, 2, number of drive strobes with CMD released between acceptance of a response request and its start bit; legal range 2..64.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_strobe  in  1  one-cycle enable marking an MMC clock rising edge; `cmd_in` is sampled only on these cycles.
- drive_strobe  in  1  one-cycle enable marking an MMC clock falling edge; `cmd_out` and `cmd_oe` change only on these cycles.
- cmd_in  in  1  CMD line level, already synchronised.
- cmd_out  out  1  CMD drive value.
- cmd_oe  out  1  CMD output enable; 1 means the card drives CMD.
- command_valid  out  1  one-cycle pulse when a complete frame has been received.
- command_index  out  6  command index from frame bits [45:40].
- command_argument  out  32  argument from frame bits [39:8].
- command_error  out  1  with `command_valid`: CRC7 mismatch or end bit equal to 0.
- start_response  in  1  request to send a response; accepted only in CMD_READY.
- drop_response  in  1  return to IDLE without responding; accepted only in CMD_READY.
- response_long  in  1  0 selects a 48-bit frame, 1 selects a 136-bit frame.
- enable_response_crc  in  1  1 replaces the frame's last byte with {CRC7, 1}.
- response_data  in  136  MSB-aligned frame; a 48-bit frame uses [135:88].
- busy  out  1  high in every state except IDLE.
- response_done  out  1  one-cycle pulse when CMD is released after the end bit.

## Operation
- States: IDLE, RECV, CMD_READY, NCR_WAIT, SEND.
- IDLE:
  - On `sample_strobe` with `cmd_in`=0, shift in the bit, set bit_count=1 and go to RECV.
  - Clear crc7 to 0, then feed it the start bit.
- RECV:
  - On each `sample_strobe`, shift `cmd_in` into a 48-bit register and increment bit_count.
  - Bits 1..40 feed crc7 using x^7+x^3+1: fb = bit ^ crc[6]; crc = {crc[5:0],0} ^ (fb ? 7'h09 : 0).
  - When bit_count reaches 48, evaluate the frame:
    - Transmission bit [46]=0 (a card-to-host frame): discard silently and return to IDLE.
    - Otherwise pulse `command_valid`, latch index and argument, and go to CMD_READY.
    - Set `command_error` = (frame[7:1] != crc7) | (frame[0]==0).
- CMD_READY:
  - `drop_response` goes to IDLE.
  - Otherwise `start_response` latches the frame, length and CRC enable, then goes to NCR_WAIT.
  - If both are asserted in the same cycle, `drop_response` wins.
  - Ignore `cmd_in` in this state.
- CRC generation when `enable_response_crc`=1:
  - 48-bit frame: CRC7 over frame bits [47:8].
  - 136-bit frame: CRC7 over bits [127:8]; the 8 header bits are excluded.
  - Bits [7:1] are replaced by the CRC and bit [0] is forced to 1.
  - The CRC may be computed serially during transmission.
- NCR_WAIT:
  - Hold `cmd_oe`=0 and `cmd_out`=1 for NCR_CYCLES drive strobes.
  - On the next drive strobe, drive the first bit (MSB) with `cmd_oe`=1 and go to SEND.
- SEND:
  - Drive one bit, MSB first, per `drive_strobe`.
  - On the drive strobe after the last bit: `cmd_oe`=0, `cmd_out`=1, pulse `response_done`, go to IDLE.
  - Ignore `cmd_in` and `start_response` in this state.
- Reset values:
  - `cmd_out`=1, `cmd_oe`=0.
  - `command_valid`, `command_error`, `response_done`, `busy` = 0.
  - `command_index`=0, `command_argument`=0.
  - State IDLE, all counters 0.

## Timing
- `command_valid` is asserted in the clock cycle after the sample strobe that captured bit 48.
- `busy` rises in the cycle after the start-bit sample.
- Earliest start bit: the (NCR_CYCLES+1)th drive strobe after `start_response` is accepted.
- A 48-bit response occupies 48 drive strobes with `cmd_oe`=1; a 136-bit response occupies 136.
- `sample_strobe` and `drive_strobe` in the same cycle: both are processed. Only one affects any given state, so there is no conflict.
- `reset` mid-frame or mid-response takes effect on that clock edge: `cmd_oe`=0 and IDLE immediately, with no `response_done`.
- `cmd_in`=0 while in CMD_READY, NCR_WAIT or SEND never starts a receive.

## Test plan
- Frame 0x40_00000000_95 (CMD0): `command_valid`, index 0, argument 0x00000000, `command_error`=0.
- Frame 0x48_000001AA_87 (CMD8): index 8, argument 0x000001AA, error 0. Same frame with last byte 0x85: error 1. Last byte 0x86 (end bit 0): error 1.
- Frame with bit [46]=0: no `command_valid`, and the block returns to IDLE with `busy`=0.
- `start_response` with `response_data[135:88]`=0x40_00000000_00, CRC enabled, NCR_CYCLES=2:
  - Two strobes with CMD released, then 48 driven bits equal to 0x4000000000 followed by 0x95.
  - `response_done` on the next strobe.
- Long response with `enable_response_crc`=0: all 136 bits from `response_data` are driven unchanged.
- `reset` during bit 20 of SEND: `cmd_oe`=0 and `cmd_out`=1 the next cycle. A following CMD0 frame is received correctly.

Source files
------------

// File: rtl/kfmmc_card_command_io_if.sv
// CMD-channel bundle between the pin/strobe logic, the card model and the command I/O block.
// The block itself takes the slave modport; the side that drives strobes and requests takes master.
interface kfmmc_card_command_io_if;
    logic         sample_strobe;
    logic         drive_strobe;
    logic         cmd_in;
    logic         cmd_out;
    logic         cmd_oe;
    logic         command_valid;
    logic [5:0]   command_index;
    logic [31:0]  command_argument;
    logic         command_error;
    logic         start_response;
    logic         drop_response;
    logic         response_long;
    logic         enable_response_crc;
    logic [135:0] response_data;
    logic         busy;
    logic         response_done;

    modport slave (
        input  sample_strobe, drive_strobe, cmd_in,
        input  start_response, drop_response, response_long,
        input  enable_response_crc, response_data,
        output cmd_out, cmd_oe, command_valid, command_index,
        output command_argument, command_error, busy, response_done
    );

    modport master (
        output sample_strobe, drive_strobe, cmd_in,
        output start_response, drop_response, response_long,
        output enable_response_crc, response_data,
        input  cmd_out, cmd_oe, command_valid, command_index,
        input  command_argument, command_error, busy, response_done
    );
endinterface

// File: rtl/kfmmc_card_command_io.sv
// Card-side MMC CMD line: receives 48-bit host commands (CRC7/end-bit checked) and
// serialises a 48- or 136-bit response after an Ncr gap; outputs registered, one bit per strobe.
module kfmmc_card_command_io #(
    parameter int NCR_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    kfmmc_card_command_io_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RECV      = 3'd1,
        CMD_READY = 3'd2,
        NCR_WAIT  = 3'd3,
        SEND      = 3'd4
    } state_t;

    localparam logic [6:0] NCR_LIMIT = 7'(NCR_CYCLES);

    state_t         state_q, state_d;
    logic [47:0]    shift_q, shift_d;
    logic [7:0]     bit_cnt_q, bit_cnt_d;
    logic [6:0]     crc_q, crc_d;
    logic [6:0]     ncr_cnt_q, ncr_cnt_d;
    logic [135:0]   resp_q, resp_d;
    logic           long_q, long_d;
    logic           crc_en_q, crc_en_d;
    logic           cmd_out_q, cmd_out_d;
    logic           cmd_oe_q, cmd_oe_d;
    logic           valid_q, valid_d;
    logic           error_q, error_d;
    logic           done_q, done_d;
    logic [5:0]     index_q, index_d;
    logic [31:0]    arg_q, arg_d;

    logic [47:0]    rx_frame;
    logic [7:0]     tx_n;
    logic [7:0]     tx_len;
    logic [7:0]     tx_hdr;
    logic           tx_bit;
    logic [6:0]     tx_crc_next;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign rx_frame = {shift_q[46:0], bus.cmd_in};

    // bit_cnt_q counts bits already driven, so tx_n is the 1-based index of the bit about to go out
    always_comb begin
        tx_n        = bit_cnt_q + 8'd1;
        tx_len      = long_q ? 8'd136 : 8'd48;
        tx_hdr      = long_q ? 8'd8 : 8'd0;
        tx_bit      = resp_q[135];
        tx_crc_next = crc_q;
        if (crc_en_q && (tx_n == tx_len)) begin
            tx_bit = 1'b1;
        end else if (crc_en_q && (tx_n >= tx_len - 8'd7)) begin
            tx_bit      = crc_q[6];
            tx_crc_next = {crc_q[5:0], 1'b0};
        end else if ((tx_n > tx_hdr) && (tx_n <= tx_len - 8'd8)) begin
            tx_crc_next = crc7_step(crc_q, resp_q[135]);
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        crc_d     = crc_q;
        ncr_cnt_d = ncr_cnt_q;
        resp_d    = resp_q;
        long_d    = long_q;
        crc_en_d  = crc_en_q;
        cmd_out_d = cmd_out_q;
        cmd_oe_d  = cmd_oe_q;
        index_d   = index_q;
        arg_d     = arg_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.sample_strobe && !bus.cmd_in) begin
                    shift_d   = {47'd0, bus.cmd_in};
                    bit_cnt_d = 8'd1;
                    crc_d     = crc7_step(7'd0, bus.cmd_in);
                    state_d   = RECV;
                end
            end
            RECV: begin
                if (bus.sample_strobe) begin
                    shift_d   = rx_frame;
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q < 8'd40) begin
                        crc_d = crc7_step(crc_q, bus.cmd_in);
                    end
                    if (bit_cnt_q == 8'd47) begin
                        bit_cnt_d = 8'd0;
                        // Card-to-host frames seen on a shared line are not ours
                        if (rx_frame[46]) begin
                            valid_d = 1'b1;
                            error_d = (rx_frame[7:1] != crc_q) | ~rx_frame[0];
                            index_d = rx_frame[45:40];
                            arg_d   = rx_frame[39:8];
                            state_d = CMD_READY;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            CMD_READY: begin
                if (bus.drop_response) begin
                    state_d = IDLE;
                end else if (bus.start_response) begin
                    resp_d    = bus.response_data;
                    long_d    = bus.response_long;
                    crc_en_d  = bus.enable_response_crc;
                    crc_d     = 7'd0;
                    ncr_cnt_d = 7'd0;
                    bit_cnt_d = 8'd0;
                    state_d   = NCR_WAIT;
                end
            end
            NCR_WAIT: begin
                if (bus.drive_strobe) begin
                    if (ncr_cnt_q < NCR_LIMIT) begin
                        ncr_cnt_d = ncr_cnt_q + 7'd1;
                        cmd_oe_d  = 1'b0;
                        cmd_out_d = 1'b1;
                    end else begin
                        cmd_oe_d  = 1'b1;
                        cmd_out_d = tx_bit;
                        crc_d     = tx_crc_next;
                        resp_d    = {resp_q[134:0], 1'b0};
                        bit_cnt_d = tx_n;
                        state_d   = SEND;
                    end
                end
            end
            SEND: begin
                if (bus.drive_strobe) begin
                    if (bit_cnt_q == tx_len) begin
                        cmd_oe_d  = 1'b0;
                        cmd_out_d = 1'b1;
                        done_d    = 1'b1;
                        bit_cnt_d = 8'd0;
                        state_d   = IDLE;
                    end else begin
                        cmd_oe_d  = 1'b1;
                        cmd_out_d = tx_bit;
                        crc_d     = tx_crc_next;
                        resp_d    = {resp_q[134:0], 1'b0};
                        bit_cnt_d = tx_n;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            crc_q     <= '0;
            ncr_cnt_q <= '0;
            resp_q    <= '0;
            long_q    <= 1'b0;
            crc_en_q  <= 1'b0;
            cmd_out_q <= 1'b1;
            cmd_oe_q  <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
            index_q   <= '0;
            arg_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            crc_q     <= crc_d;
            ncr_cnt_q <= ncr_cnt_d;
            resp_q    <= resp_d;
            long_q    <= long_d;
            crc_en_q  <= crc_en_d;
            cmd_out_q <= cmd_out_d;
            cmd_oe_q  <= cmd_oe_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            done_q    <= done_d;
            index_q   <= index_d;
            arg_q     <= arg_d;
        end
    end

    assign bus.cmd_out          = cmd_out_q;
    assign bus.cmd_oe           = cmd_oe_q;
    assign bus.command_valid    = valid_q;
    assign bus.command_error    = error_q;
    assign bus.command_index    = index_q;
    assign bus.command_argument = arg_q;
    assign bus.response_done    = done_q;
    assign bus.busy             = (state_q != IDLE);

endmodule

// File: tb/tb_kfmmc_card_command_io.sv
// Directed bench for kfmmc_card_command_io: command receive, CRC/framing errors, responses, reset.
module tb_kfmmc_card_command_io;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    kfmmc_card_command_io_if bus();

    kfmmc_card_command_io #(.NCR_CYCLES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic send_frame(input logic [47:0] f, output int vld_cnt, output int vld_at,
                              output logic [5:0] idx, output logic [31:0] arg,
                              output logic err, output logic busy_start);
        vld_cnt = 0; vld_at = -1; idx = '0; arg = '0; err = 1'b0; busy_start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clock);
            bus.cmd_in = f[47-i];
            bus.sample_strobe = 1'b1;
            @(negedge clock);
            bus.sample_strobe = 1'b0;
            bus.cmd_in = 1'b1;
            if (i == 0) busy_start = bus.busy;
            if (bus.command_valid) begin
                vld_cnt++; vld_at = i;
                idx = bus.command_index; arg = bus.command_argument; err = bus.command_error;
            end
        end
        @(negedge clock);
        if (bus.command_valid) vld_cnt++;
    endtask

    task automatic request_response(input logic lng, input logic crc_en, input logic [135:0] data);
        @(negedge clock);
        bus.start_response = 1'b1;
        bus.response_long = lng;
        bus.enable_response_crc = crc_en;
        bus.response_data = data;
        @(negedge clock);
        bus.start_response = 1'b0;
    endtask

    task automatic drop_now();
        @(negedge clock);
        bus.drop_response = 1'b1;
        @(negedge clock);
        bus.drop_response = 1'b0;
    endtask

    // Both strobes every bit time with cmd_in low: the sample side must stay inert while responding
    task automatic run_strobes(input int n, output logic [255:0] oe_v, output logic [255:0] out_v,
                               output logic [255:0] done_v);
        oe_v = '0; out_v = '0; done_v = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            bus.drive_strobe = 1'b1;
            bus.sample_strobe = 1'b1;
            bus.cmd_in = 1'b0;
            @(negedge clock);
            bus.drive_strobe = 1'b0;
            bus.sample_strobe = 1'b0;
            oe_v[k] = bus.cmd_oe;
            out_v[k] = bus.cmd_out;
            done_v[k] = bus.response_done;
        end
        bus.cmd_in = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        total++;
        if ({bus.cmd_out, bus.cmd_oe, bus.busy} !== 3'b100) begin
            bad++; $display("FAIL reset_pins got=%b exp=100", {bus.cmd_out, bus.cmd_oe, bus.busy});
        end
        total++;
        if ({bus.command_valid, bus.command_error, bus.response_done} !== 3'b000) begin
            bad++; $display("FAIL reset_pulses got=%b exp=000",
                            {bus.command_valid, bus.command_error, bus.response_done});
        end
        total++;
        if ({bus.command_index, bus.command_argument} !== 38'd0) begin
            bad++; $display("FAIL reset_cmd got=%h exp=0", {bus.command_index, bus.command_argument});
        end
    endtask

    task automatic test_cmd_frames();
        int vc, va; logic [5:0] idx; logic [31:0] arg; logic err, bs;
        send_frame(48'h40_00000000_95, vc, va, idx, arg, err, bs);
        total++;
        if (bs !== 1'b1) begin bad++; $display("FAIL cmd0_busy_start got=%b exp=1", bs); end
        total++;
        if ({vc, va} !== {32'd1, 32'd47}) begin
            bad++; $display("FAIL cmd0_valid count=%0d at=%0d exp count=1 at=47", vc, va);
        end
        total++;
        if ({idx, arg, err} !== {6'd0, 32'h0, 1'b0}) begin
            bad++; $display("FAIL cmd0_fields got=%h/%h/%b exp=00/00000000/0", idx, arg, err);
        end
        drop_now();

        send_frame(48'h48_000001AA_87, vc, va, idx, arg, err, bs);
        total++;
        if ({vc, idx, arg, err} !== {32'd1, 6'd8, 32'h000001AA, 1'b0}) begin
            bad++; $display("FAIL cmd8_fields got=%0d/%h/%h/%b exp=1/08/000001aa/0", vc, idx, arg, err);
        end
        drop_now();

        send_frame(48'h48_000001AA_85, vc, va, idx, arg, err, bs);
        total++;
        if ({vc, err} !== {32'd1, 1'b1}) begin
            bad++; $display("FAIL cmd8_badcrc got=%0d/%b exp=1/1", vc, err);
        end
        drop_now();

        send_frame(48'h48_000001AA_86, vc, va, idx, arg, err, bs);
        total++;
        if ({vc, err} !== {32'd1, 1'b1}) begin
            bad++; $display("FAIL cmd8_endbit got=%0d/%b exp=1/1", vc, err);
        end
        drop_now();

        send_frame(48'h08_000001AA_87, vc, va, idx, arg, err, bs);
        total++;
        if ({vc, bus.busy} !== {32'd0, 1'b0}) begin
            bad++; $display("FAIL card_frame_discard got=%0d/%b exp=0/0", vc, bus.busy);
        end
    endtask

    task automatic test_drop_and_ignore();
        int vc, va; logic [5:0] idx; logic [31:0] arg; logic err, bs;
        logic [255:0] oe_v, out_v, done_v;
        send_frame(48'h48_000001AA_87, vc, va, idx, arg, err, bs);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); bus.cmd_in = 1'b0; bus.sample_strobe = 1'b1;
            @(negedge clock); bus.sample_strobe = 1'b0; bus.cmd_in = 1'b1;
        end
        total++;
        if ({bus.busy, bus.command_valid} !== 2'b10) begin
            bad++; $display("FAIL ready_ignores_cmd got=%b exp=10", {bus.busy, bus.command_valid});
        end
        @(negedge clock);
        bus.drop_response = 1'b1; bus.start_response = 1'b1;
        @(negedge clock);
        bus.drop_response = 1'b0; bus.start_response = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL drop_wins got=%b exp=0", bus.busy); end
        bus.cmd_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock); bus.drive_strobe = 1'b1;
            @(negedge clock); bus.drive_strobe = 1'b0;
            oe_v[k] = bus.cmd_oe;
        end
        total++;
        if (oe_v[5:0] !== 6'd0) begin bad++; $display("FAIL drop_no_drive got=%b exp=000000", oe_v[5:0]); end
    endtask

    task automatic test_short_response();
        int vc, va; logic [5:0] idx; logic [31:0] arg; logic err, bs;
        logic [255:0] oe_v, out_v, done_v, exp_oe, exp_out, exp_done;
        logic [47:0] fr;
        fr = 48'h40_00000000_95;
        send_frame(48'h40_00000000_95, vc, va, idx, arg, err, bs);
        request_response(1'b0, 1'b1, {48'h40_00000000_00, {88{1'b1}}});
        run_strobes(51, oe_v, out_v, done_v);
        exp_oe = '0; exp_out = '0; exp_done = '0;
        for (int k = 0; k < 51; k++) begin
            exp_oe[k]  = (k >= 2 && k <= 49);
            exp_out[k] = (k >= 2 && k <= 49) ? fr[47-(k-2)] : 1'b1;
            exp_done[k] = (k == 50);
        end
        total++;
        if (oe_v !== exp_oe) begin bad++; $display("FAIL short_oe got=%h exp=%h", oe_v, exp_oe); end
        total++;
        if (out_v !== exp_out) begin bad++; $display("FAIL short_bits got=%h exp=%h", out_v, exp_out); end
        total++;
        if (done_v !== exp_done) begin bad++; $display("FAIL short_done got=%h exp=%h", done_v, exp_done); end
        @(negedge clock);
        total++;
        if ({bus.response_done, bus.busy, bus.cmd_oe, bus.cmd_out} !== 4'b0001) begin
            bad++; $display("FAIL short_after got=%b exp=0001",
                            {bus.response_done, bus.busy, bus.cmd_oe, bus.cmd_out});
        end
    endtask

    task automatic test_long_response();
        int vc, va; logic [5:0] idx; logic [31:0] arg; logic err, bs;
        logic [255:0] oe_v, out_v, done_v, exp_oe, exp_out, exp_done;
        logic [135:0] fr;
        fr = 136'h3F_0123456789ABCDEF_FEDCBA98765432_10;
        send_frame(48'h48_000001AA_87, vc, va, idx, arg, err, bs);
        request_response(1'b1, 1'b0, fr);
        run_strobes(139, oe_v, out_v, done_v);
        exp_oe = '0; exp_out = '0; exp_done = '0;
        for (int k = 0; k < 139; k++) begin
            exp_oe[k]  = (k >= 2 && k <= 137);
            exp_out[k] = (k >= 2 && k <= 137) ? fr[135-(k-2)] : 1'b1;
            exp_done[k] = (k == 138);
        end
        total++;
        if (oe_v !== exp_oe) begin bad++; $display("FAIL long_oe got=%h exp=%h", oe_v, exp_oe); end
        total++;
        if (out_v !== exp_out) begin bad++; $display("FAIL long_bits got=%h exp=%h", out_v, exp_out); end
        total++;
        if (done_v !== exp_done) begin bad++; $display("FAIL long_done got=%h exp=%h", done_v, exp_done); end
    endtask

    task automatic test_reset_mid_send();
        int vc, va; logic [5:0] idx; logic [31:0] arg; logic err, bs;
        logic [255:0] oe_v, out_v, done_v;
        send_frame(48'h40_00000000_95, vc, va, idx, arg, err, bs);
        request_response(1'b0, 1'b1, {48'h40_00000000_00, 88'd0});
        run_strobes(22, oe_v, out_v, done_v);
        total++;
        if ({oe_v[21], bus.busy} !== 2'b11) begin
            bad++; $display("FAIL mid_send_active got=%b exp=11", {oe_v[21], bus.busy});
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({bus.cmd_oe, bus.cmd_out, bus.busy, bus.response_done} !== 4'b0100) begin
            bad++; $display("FAIL reset_mid_send got=%b exp=0100",
                            {bus.cmd_oe, bus.cmd_out, bus.busy, bus.response_done});
        end
        reset = 1'b0;
        send_frame(48'h40_00000000_95, vc, va, idx, arg, err, bs);
        total++;
        if ({vc, idx, arg, err} !== {32'd1, 6'd0, 32'h0, 1'b0}) begin
            bad++; $display("FAIL cmd0_after_reset got=%0d/%h/%h/%b exp=1/00/00000000/0", vc, idx, arg, err);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.sample_strobe = 1'b0;
        bus.drive_strobe = 1'b0;
        bus.cmd_in = 1'b1;
        bus.start_response = 1'b0;
        bus.drop_response = 1'b0;
        bus.response_long = 1'b0;
        bus.enable_response_crc = 1'b0;
        bus.response_data = '0;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b0;
        test_reset();
        test_cmd_frames();
        test_drop_and_ignore();
        test_short_response();
        test_long_response();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
